vga_sprite_engine: RTL and testbench
====================================

// Module: vga_sprite_engine
// PURPOSE
//  Pixel-generation stage directly downstream of vga_control in the VGA path.
//  Consumes h_count/v_count/bright and raw syncs, and draws a solid square sprite on a background.
//  The sprite bounces off the active-area edges, moving once per frame.
//  Registers rgb and re-times hs/vs by one cycle so colour and sync leave aligned.
// PARAMETERS
//  CW         10      width of h_count/v_count and of position registers
//  H_ACTIVE   640     visible pixels per line
//  V_ACTIVE   480     visible lines per frame
//  BOX_SIZE   32      sprite edge length in pixels
//  STEP       2       pixels moved per frame on each axis (1..BOX_SIZE)
//  BOX_COLOR  3'b100  sprite colour
//  BG_COLOR   3'b001  background colour
// PORTS
//  clk_25      in   1   pixel clock, all logic on rising edge
//  reset_n     in   1   synchronous, active-low reset
//  h_count     in   CW  current column from vga_control
//  v_count     in   CW  current line from vga_control
//  bright      in   1   1 = inside visible area
//  h_sync_in   in   1   raw hsync from vga_control (active-low)
//  v_sync_in   in   1   raw vsync from vga_control (active-low)
//  rgb         out  3   registered pixel colour
//  hs          out  1   h_sync_in delayed 1 cycle
//  vs          out  1   v_sync_in delayed 1 cycle
//  frame_tick  out  1   1-cycle pulse per frame, when position updates
// BEHAVIOUR
//  - One clock (clk_25); reset is synchronous and active-low (reset_n sampled on clk_25 rising edge).
//  - Reset values: rgb=0, hs=1, vs=1, frame_tick=0.
//    Internal reset values: box_x=0, box_y=0, dir_x=right, dir_y=down, vsync_d=1.
//  - Reset mid-frame: all state returns to reset values on that edge; motion restarts from (0,0).
//  - Frame event: vsync_d==1 && v_sync_in==0 (falling edge of vsync).
//    frame_tick=1 on the cycle after the event edge, else 0.
//    Updates occur only in vertical blanking, so a drawn frame never tears.
//  - Position update on frame event, each axis independent; both may flip in the same frame at a corner.
//    Right: nx=box_x+STEP. If nx > H_ACTIVE-BOX_SIZE, then box_x=H_ACTIVE-BOX_SIZE and dir_x=left;
//    otherwise box_x=nx.
//    Left: if box_x < STEP, then box_x=0 and dir_x=right; otherwise box_x=box_x-STEP.
//    Y axis: same rules using V_ACTIVE, box_y, dir_y (down/up).
//    Compare in CW+1 bits; no wrap-around permitted.
//  - Hit test (combinational): inside = (h_count>=box_x) && (h_count<box_x+BOX_SIZE)
//    && (v_count>=box_y) && (v_count<box_y+BOX_SIZE).
//  - Colour (registered, latency 1 cycle from counts):
//    rgb <= !bright ? 3'b000 : inside ? BOX_COLOR : BG_COLOR.
//  - hs <= h_sync_in; vs <= v_sync_in (same 1-cycle latency as rgb).
// CONFIGURATION
//  VGA_SPRITE_BORDER_EN defined:
//    - When bright=1 and h_count==0, h_count==H_ACTIVE-1, v_count==0 or v_count==V_ACTIVE-1,
//      rgb is forced to 3'b111.
//    - Border has priority over the sprite; latency is unchanged.
//  Macro undefined: no border logic; the colour rule above applies unchanged.
// TESTING
//  1. reset_n=0 for 3 cycles mid-line -> rgb=0, hs=1, vs=1, frame_tick=0; first frame draws box at (0,0).
//  2. After reset: h=0,v=0,bright=1 -> rgb=3'b100 next cycle.
//     h=32,v=0 -> 3'b001. h=31,v=31 -> 3'b100. bright=0 -> 3'b000.
//  3. v_sync_in 1->0 -> frame_tick=1 exactly one cycle after that edge; box now at (2,2);
//     pixel h=1,v=1 -> 3'b001, h=2,v=2 -> 3'b100.
//  4. 304 frame events -> box_x=608.
//     Frame 305: box_x stays 608, dir_x=left. Frame 306: box_x=606.
//     Y axis: 224 events -> box_y=448; next event flips dir_y.
//  5. Toggle h_sync_in/v_sync_in arbitrarily -> hs/vs equal the inputs delayed exactly 1 cycle,
//     aligned with the rgb for the same counts.
//  6. With VGA_SPRITE_BORDER_EN: h=0,v=0 (inside box) -> rgb=3'b111; h=639,v=100 -> 3'b111.
//     Without the macro: h=0,v=0 -> 3'b100.

Source files
------------

// File: rtl/vga_sprite_engine.sv
// Pixel stage after vga_control: bouncing square sprite over a background, sync re-timed by one cycle.
// Optional white frame border: define VGA_SPRITE_BORDER_EN.
module vga_sprite_engine #(
   parameter int unsigned CW        = 10,
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned BOX_SIZE  = 32,
   parameter int unsigned STEP      = 2,
   parameter logic [2:0]  BOX_COLOR = 3'b100,
   parameter logic [2:0]  BG_COLOR  = 3'b001
) (
   input  logic          clk_25,
   input  logic          reset_n,
   input  logic [CW-1:0] h_count,
   input  logic [CW-1:0] v_count,
   input  logic          bright,
   input  logic          h_sync_in,
   input  logic          v_sync_in,
   output logic [2:0]    rgb,
   output logic          hs,
   output logic          vs,
   output logic          frame_tick
);
   localparam logic [CW:0]   STEP_W = (CW+1)'(STEP);
   localparam logic [CW-1:0] STEP_N = CW'(STEP);
   localparam logic [CW:0]   SIZE_W = (CW+1)'(BOX_SIZE);
   localparam logic [CW:0]   X_MAX  = (CW+1)'(H_ACTIVE - BOX_SIZE);
   localparam logic [CW:0]   Y_MAX  = (CW+1)'(V_ACTIVE - BOX_SIZE);

   logic [CW-1:0] box_x_r, box_y_r;
   logic          dir_x_r, dir_y_r;   // 1 = right / down
   logic [2:0]    rgb_r;
   logic          hs_r, vs_r, frame_tick_r;
   logic          frame_event_s, inside_s;
   logic [CW:0]   step_x_s, step_y_s;
   logic [2:0]    pix_s;

   // One axis move, evaluated one bit wider than the counters so the edge test never wraps.
   // Result is {new_dir, new_pos}.
   function automatic logic [CW:0] step_axis(input logic [CW-1:0] pos,
                                             input logic          fwd,
                                             input logic [CW:0]   lim);
      logic [CW:0] nxt;
      nxt = {1'b0, pos} + STEP_W;
      if (fwd) begin
         if (nxt > lim) step_axis = {1'b0, lim[CW-1:0]};
         else           step_axis = {1'b1, nxt[CW-1:0]};
      end else begin
         if ({1'b0, pos} < STEP_W) step_axis = {1'b1, {CW{1'b0}}};
         else                      step_axis = {1'b0, pos - STEP_N};
      end
   endfunction

   // vs_r doubles as the delayed vsync, so its falling edge marks the start of vertical blanking
   assign frame_event_s = vs_r & ~v_sync_in;
   assign step_x_s      = step_axis(box_x_r, dir_x_r, X_MAX);
   assign step_y_s      = step_axis(box_y_r, dir_y_r, Y_MAX);

   assign inside_s = ({1'b0, h_count} >= {1'b0, box_x_r}) &&
                     ({1'b0, h_count} <  ({1'b0, box_x_r} + SIZE_W)) &&
                     ({1'b0, v_count} >= {1'b0, box_y_r}) &&
                     ({1'b0, v_count} <  ({1'b0, box_y_r} + SIZE_W));

`ifdef VGA_SPRITE_BORDER_EN
   logic border_s;
   assign border_s = (h_count == {CW{1'b0}}) || (h_count == CW'(H_ACTIVE - 1)) ||
                     (v_count == {CW{1'b0}}) || (v_count == CW'(V_ACTIVE - 1));
`endif

   // Pixel colour selection; blanking wins, then border (if built), then sprite
   always_comb begin
      pix_s = BG_COLOR;
      if (!bright) begin
         pix_s = 3'b000;
`ifdef VGA_SPRITE_BORDER_EN
      end else if (border_s) begin
         pix_s = 3'b111;
`endif
      end else if (inside_s) begin
         pix_s = BOX_COLOR;
      end else begin
         pix_s = BG_COLOR;
      end
   end

   // Output registers, sync delay and once-per-frame sprite motion
   always_ff @(posedge clk_25) begin
      if (!reset_n) begin
         rgb_r        <= 3'b000;
         hs_r         <= 1'b1;
         vs_r         <= 1'b1;
         frame_tick_r <= 1'b0;
         box_x_r      <= {CW{1'b0}};
         box_y_r      <= {CW{1'b0}};
         dir_x_r      <= 1'b1;
         dir_y_r      <= 1'b1;
      end else begin
         rgb_r        <= pix_s;
         hs_r         <= h_sync_in;
         vs_r         <= v_sync_in;
         frame_tick_r <= frame_event_s;
         if (frame_event_s) begin
            box_x_r <= step_x_s[CW-1:0];
            dir_x_r <= step_x_s[CW];
            box_y_r <= step_y_s[CW-1:0];
            dir_y_r <= step_y_s[CW];
         end
      end
   end

   assign rgb        = rgb_r;
   assign hs         = hs_r;
   assign vs         = vs_r;
   assign frame_tick = frame_tick_r;
endmodule

// File: tb/tb_vga_sprite_engine.sv
// Directed bench for vga_sprite_engine: vector table plus reset, bounce and sync-timing sequences.
// Border expectations follow VGA_SPRITE_BORDER_EN when the bench is built with it.
module tb_vga_sprite_engine;
   logic       clk_25 = 1'b0;
   logic       reset_n = 1'b1;
   logic [9:0] h_count = 10'd0, v_count = 10'd0;
   logic       bright = 1'b0, h_sync_in = 1'b1, v_sync_in = 1'b1;
   logic [2:0] rgb;
   logic       hs, vs, frame_tick;
   int         checks = 0, errors = 0;

`ifdef VGA_SPRITE_BORDER_EN
   localparam bit BORDER = 1'b1;
`else
   localparam bit BORDER = 1'b0;
`endif

   typedef struct {
      logic [9:0] h, v;
      logic       b, hsi, vsi;
      logic [2:0] rgb;
      logic       hs, vs;
   } vec_t;
   vec_t tbl[11];

   vga_sprite_engine dut (
      .clk_25(clk_25), .reset_n(reset_n), .h_count(h_count), .v_count(v_count),
      .bright(bright), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
      .rgb(rgb), .hs(hs), .vs(vs), .frame_tick(frame_tick)
   );

   always #5 clk_25 = ~clk_25;

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic step(input logic [9:0] h, input logic [9:0] v, input logic b,
                       input logic hsi, input logic vsi);
      h_count = h; v_count = v; bright = b; h_sync_in = hsi; v_sync_in = vsi;
      @(posedge clk_25);
      #1;
   endtask

   task automatic pixel(input string name, input logic [9:0] h, input logic [9:0] v,
                        input logic [2:0] exp);
      step(h, v, 1'b1, 1'b1, 1'b1);
      check(name, rgb, exp);
   endtask

   // vsync falls (event), stays low one more cycle, then returns high
   task automatic frame_event();
      step(10'd1023, 10'd1023, 1'b0, 1'b1, 1'b0);
      check("frame_tick_high", {2'b00, frame_tick}, 3'b001);
      step(10'd1023, 10'd1023, 1'b0, 1'b1, 1'b0);
      check("frame_tick_once", {2'b00, frame_tick}, 3'b000);
      step(10'd1023, 10'd1023, 1'b0, 1'b1, 1'b1);
   endtask

   initial begin
      logic hsi, vsi, b, pv;
      tbl[0]  = '{10'd0,   10'd0,   1'b1, 1'b1, 1'b1, BORDER ? 3'b111 : 3'b100, 1'b1, 1'b1};
      tbl[1]  = '{10'd32,  10'd0,   1'b1, 1'b1, 1'b1, BORDER ? 3'b111 : 3'b001, 1'b1, 1'b1};
      tbl[2]  = '{10'd31,  10'd31,  1'b1, 1'b1, 1'b1, 3'b100, 1'b1, 1'b1};
      tbl[3]  = '{10'd31,  10'd31,  1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 1'b1};
      tbl[4]  = '{10'd0,   10'd32,  1'b1, 1'b1, 1'b1, BORDER ? 3'b111 : 3'b001, 1'b1, 1'b1};
      tbl[5]  = '{10'd639, 10'd100, 1'b1, 1'b1, 1'b1, BORDER ? 3'b111 : 3'b001, 1'b1, 1'b1};
      tbl[6]  = '{10'd31,  10'd32,  1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 1'b1};
      tbl[7]  = '{10'd32,  10'd31,  1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 1'b1};
      tbl[8]  = '{10'd15,  10'd15,  1'b1, 1'b1, 1'b1, 3'b100, 1'b1, 1'b1};
      tbl[9]  = '{10'd700, 10'd500, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1};
      tbl[10] = '{10'd638, 10'd478, 1'b1, 1'b1, 1'b1, 3'b001, 1'b1, 1'b1};

      // Mid-line activity, then a 3-cycle reset
      step(10'd100, 10'd100, 1'b1, 1'b0, 1'b0);
      step(10'd101, 10'd100, 1'b1, 1'b0, 1'b0);
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(10'(102 + i), 10'd100, 1'b1, 1'b0, 1'b0);
         check("rst_rgb", rgb, 3'b000);
         check("rst_hs", {2'b00, hs}, 3'b001);
         check("rst_vs", {2'b00, vs}, 3'b001);
         check("rst_tick", {2'b00, frame_tick}, 3'b000);
      end
      reset_n = 1'b1;

      // Sprite at (0,0)
      for (int i = 0; i < 11; i++) begin
         step(tbl[i].h, tbl[i].v, tbl[i].b, tbl[i].hsi, tbl[i].vsi);
         check($sformatf("vec%0d_rgb", i), rgb, tbl[i].rgb);
         check($sformatf("vec%0d_hs", i), {2'b00, hs}, {2'b00, tbl[i].hs});
         check($sformatf("vec%0d_vs", i), {2'b00, vs}, {2'b00, tbl[i].vs});
      end

      // First frame: sprite moves to (2,2)
      frame_event();
      pixel("f1_h1v1", 10'd1, 10'd1, 3'b001);
      pixel("f1_h2v2", 10'd2, 10'd2, 3'b100);
      pixel("f1_h33v33", 10'd33, 10'd33, 3'b100);
      pixel("f1_h34v2", 10'd34, 10'd2, 3'b001);

      // Bounce sequence up to frame 306
      for (int n = 2; n <= 306; n++) begin
         frame_event();
         if (n == 224) begin
            pixel("f224_in", 10'd448, 10'd448, 3'b100);
            pixel("f224_above", 10'd448, 10'd447, 3'b001);
            pixel("f224_far", 10'd479, 10'd478, 3'b100);
         end
         if (n == 225) begin
            pixel("f225_in", 10'd450, 10'd448, 3'b100);
            pixel("f225_above", 10'd450, 10'd447, 3'b001);
         end
         if (n == 226) begin
            pixel("f226_in", 10'd452, 10'd446, 3'b100);
            pixel("f226_above", 10'd452, 10'd445, 3'b001);
         end
         if (n == 304) begin
            pixel("f304_in", 10'd608, 10'd290, 3'b100);
            pixel("f304_left", 10'd607, 10'd290, 3'b001);
            pixel("f304_far", 10'd638, 10'd321, 3'b100);
            pixel("f304_below", 10'd608, 10'd322, 3'b001);
            pixel("f304_above", 10'd608, 10'd289, 3'b001);
         end
         if (n == 305) begin
            pixel("f305_in", 10'd608, 10'd288, 3'b100);
            pixel("f305_left", 10'd607, 10'd288, 3'b001);
         end
         if (n == 306) begin
            pixel("f306_in", 10'd606, 10'd286, 3'b100);
            pixel("f306_left", 10'd605, 10'd286, 3'b001);
            pixel("f306_right", 10'd638, 10'd286, 3'b001);
         end
      end

      // Arbitrary sync toggling: 1-cycle delay, aligned with rgb and frame_tick
      pv = 1'b1;
      for (int i = 0; i < 40; i++) begin
         hsi = 1'($urandom);
         vsi = 1'($urandom);
         b   = 1'($urandom);
         step(10'd1023, 10'd1023, b, hsi, vsi);
         check("sync_hs", {2'b00, hs}, {2'b00, hsi});
         check("sync_vs", {2'b00, vs}, {2'b00, vsi});
         check("sync_rgb", rgb, b ? 3'b001 : 3'b000);
         check("sync_tick", {2'b00, frame_tick}, {2'b00, pv & ~vsi});
         pv = vsi;
      end

      // Mid-frame reset restarts motion from (0,0)
      reset_n = 1'b0;
      step(10'd300, 10'd200, 1'b1, 1'b0, 1'b1);
      step(10'd301, 10'd200, 1'b1, 1'b0, 1'b1);
      reset_n = 1'b1;
      pixel("rst2_h0v0", 10'd0, 10'd0, BORDER ? 3'b111 : 3'b100);
      pixel("rst2_h5v5", 10'd5, 10'd5, 3'b100);
      frame_event();
      pixel("rst2_h1v1", 10'd1, 10'd1, 3'b001);
      pixel("rst2_h2v2", 10'd2, 10'd2, 3'b100);
      pixel("rst2_h34v34", 10'd34, 10'd34, 3'b001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
